// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner selection for a shared tri-state bus.
// Each tenure is followed by a bus-idle turnaround of TURN_CYC cycles, so two
// drivers never overlap. Only this block asserts the bus output enable.
// Optional feature macro: TRI_BUS_ARB_TIMEOUT_EN (bounds each tenure to
// MAX_TENURE grant cycles and pulses timeout on a forced release).
`timescale 1ns/1ps

module tri_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 8,
    parameter int TURN_CYC   = 1,
    parameter int MAX_TENURE = 16,
    localparam int OW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [OW-1:0]         owner,
    output logic                  bus_oe,
    output logic [WIDTH-1:0]      bus_dout,
    output logic                  busy,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [3:0]    TURN_LOAD = 4'(TURN_CYC - 1);
    localparam logic [OW-1:0] PTR_RST   = OW'(NREQ - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [3:0]        turn_cnt_q, turn_cnt_d;
    logic              timeout_q, timeout_d;

    logic              arb_found;
    logic [OW-1:0]     arb_win;
    logic              tenure_end;

    logic [WIDTH-1:0]  wdata_arr [NREQ];

`ifdef TRI_BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TEN_LAST = 8'(MAX_TENURE - 1);
    logic [7:0]        ten_cnt_q, ten_cnt_d;
`endif

    // Split the flat write-data vector into one word per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_wdata
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting just after the previous owner.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_win   = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + 1 + i) % NREQ;
            if (!arb_found && req[idx]) begin
                arb_found = 1'b1;
                arb_win   = OW'(idx);
            end
        end
    end

    // A tenure ends when the owner drops req, or on its last data cycle.
    assign tenure_end = !req[owner_q] || last[owner_q];

    // Next-state logic: tenure tracking, turnaround countdown, arbitration.
    always_comb begin
        logic arb_go;
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        turn_cnt_d = turn_cnt_q;
        timeout_d  = 1'b0;
        arb_go     = 1'b0;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
        ten_cnt_d  = ten_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                arb_go = 1'b1;
            end
            ST_GRANT: begin
                if (tenure_end) begin
                    state_d    = ST_TURN;
                    gnt_d      = '0;
                    turn_cnt_d = TURN_LOAD;
                end
`ifdef TRI_BUS_ARB_TIMEOUT_EN
                else if (ten_cnt_q == TEN_LAST) begin
                    // Owner overstayed: release it; ptr already points at it,
                    // so it drops to lowest priority in the next search.
                    state_d    = ST_TURN;
                    gnt_d      = '0;
                    turn_cnt_d = TURN_LOAD;
                    timeout_d  = 1'b1;
                end else begin
                    ten_cnt_d  = ten_cnt_q + 8'd1;
                end
`endif
            end
            ST_TURN: begin
                if (turn_cnt_q == 4'd0) begin
                    arb_go = 1'b1;
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        if (arb_go) begin
            if (arb_found) begin
                state_d = ST_GRANT;
                gnt_d   = NREQ'(1) << arb_win;
                owner_d = arb_win;
                ptr_d   = arb_win;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
                ten_cnt_d = 8'd0;
`endif
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        end
    end

    // State registers; reset clears grants immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= PTR_RST;
            turn_cnt_q <= 4'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            turn_cnt_q <= turn_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef TRI_BUS_ARB_TIMEOUT_EN
    // Grant-cycle counter for the current tenure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ten_cnt_q <= 8'd0;
        end else begin
            ten_cnt_q <= ten_cnt_d;
        end
    end
`endif

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign bus_oe   = |gnt_q;
    assign bus_dout = bus_oe ? wdata_arr[owner_q] : '0;
    assign busy     = (state_q != ST_IDLE);
`ifdef TRI_BUS_ARB_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter: a vector table for the per-cycle
// behaviour plus hand-written sequences for turnaround length, asynchronous
// reset and tenure timeout.
`timescale 1ns/1ps

module tb_tri_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  last = '0;
    logic [31:0] wdata = 32'hD3C2B1A0;

    logic [3:0]  gnt_a, gnt_b;
    logic [1:0]  owner_a, owner_b;
    logic        oe_a, oe_b;
    logic [7:0]  dout_a, dout_b;
    logic        busy_a, busy_b;
    logic        to_a, to_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(.NREQ(4), .WIDTH(8), .TURN_CYC(1), .MAX_TENURE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .wdata(wdata),
        .gnt(gnt_a), .owner(owner_a), .bus_oe(oe_a), .bus_dout(dout_a),
        .busy(busy_a), .timeout(to_a)
    );

    tri_bus_arbiter #(.NREQ(4), .WIDTH(8), .TURN_CYC(3), .MAX_TENURE(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .wdata(wdata),
        .gnt(gnt_b), .owner(owner_b), .bus_oe(oe_b), .bus_dout(dout_b),
        .busy(busy_b), .timeout(to_b)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    localparam int NV = 30;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] dexp(input logic [3:0] g, input logic [1:0] o);
        logic [7:0] ov;
        ov = {6'b0, o};
        return (g != 4'b0) ? (8'hA0 + 8'h11 * ov) : 8'h00;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        #1;
        chk("rst_gnt", {28'b0, gnt_a}, 32'h0);
        chk("rst_owner", {30'b0, owner_a}, 32'h0);
        chk("rst_oe", {31'b0, oe_a}, 32'h0);
        chk("rst_dout", {24'b0, dout_a}, 32'h0);
        chk("rst_busy", {31'b0, busy_a}, 32'h0);
        chk("rst_timeout", {31'b0, to_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l);
        @(negedge clk);
        req  = r;
        last = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gap;
        // rst, req, last, exp gnt, exp owner, exp busy
        // Single requester, last on 3rd grant cycle.
        vt[0]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vt[1]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vt[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vt[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1};
        vt[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        // All requesting, one-cycle tenures: order 0,1,2,3,0.
        vt[5]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vt[6]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b1};
        vt[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
        vt[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd1, 1'b1};
        vt[9]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
        vt[10] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd2, 1'b1};
        vt[11] = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
        vt[12] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd3, 1'b1};
        vt[13] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vt[14] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1};
        vt[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        // Owner 0 drops req mid-tenure, requester 2 follows.
        vt[16] = '{1'b1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vt[17] = '{1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1};
        vt[18] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1};
        vt[19] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
        vt[20] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1};
        vt[21] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
        // Non-owner last ignored; sole requester wins again after TURN.
        vt[22] = '{1'b1, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1};
        vt[23] = '{1'b0, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1};
        vt[24] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b1};
        vt[25] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1};
        vt[26] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1};
        vt[27] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1};
        vt[28] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1};
        vt[29] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0};

        for (int i = 0; i < NV; i++) begin
            if (vt[i].rst) do_reset();
            step(vt[i].req, vt[i].last);
            $display("[TB] vec %0d req=%b last=%b gnt=%b owner=%0d oe=%b dout=%h busy=%b",
                     i, vt[i].req, vt[i].last, gnt_a, owner_a, oe_a, dout_a, busy_a);
            chk($sformatf("v%0d_gnt", i), {28'b0, gnt_a}, {28'b0, vt[i].gnt});
            chk($sformatf("v%0d_owner", i), {30'b0, owner_a}, {30'b0, vt[i].owner});
            chk($sformatf("v%0d_oe", i), {31'b0, oe_a}, {31'b0, (vt[i].gnt != 4'b0)});
            chk($sformatf("v%0d_dout", i), {24'b0, dout_a}, {24'b0, dexp(vt[i].gnt, vt[i].owner)});
            chk($sformatf("v%0d_busy", i), {31'b0, busy_a}, {31'b0, vt[i].busy});
            chk($sformatf("v%0d_timeout", i), {31'b0, to_a}, 32'h0);
            chk($sformatf("v%0d_onehot", i), {31'b0, $onehot0(gnt_a)}, 32'h1);
        end

        // Three-cycle turnaround on dut_b between requesters 1 and 2.
        do_reset();
        step(4'b0110, 4'b0000);
        $display("[TB] turn3 grant gnt_b=%b owner_b=%0d", gnt_b, owner_b);
        chk("t3_first_gnt", {28'b0, gnt_b}, 32'h2);
        step(4'b0110, 4'b0010);
        chk("t3_end_oe", {31'b0, oe_b}, 32'h0);
        gap = 1;
        for (int c = 0; c < 20; c++) begin
            step(4'b0110, 4'b0000);
            if (gnt_b != 4'b0) break;
            gap++;
        end
        $display("[TB] turn3 gap=%0d gnt_b=%b owner_b=%0d", gap, gnt_b, owner_b);
        chk("t3_gap", gap, 32'd3);
        chk("t3_next_gnt", {28'b0, gnt_b}, 32'h4);
        chk("t3_next_owner", {30'b0, owner_b}, 32'h2);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Asynchronous reset in the middle of a grant to requester 2.
        do_reset();
        step(4'b0100, 4'b0000);
        chk("ar_pre_gnt", {28'b0, gnt_a}, 32'h4);
        chk("ar_pre_owner", {30'b0, owner_a}, 32'h2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset gnt=%b oe=%b busy=%b", gnt_a, oe_a, busy_a);
        chk("ar_gnt", {28'b0, gnt_a}, 32'h0);
        chk("ar_oe", {31'b0, oe_a}, 32'h0);
        chk("ar_busy", {31'b0, busy_a}, 32'h0);
        chk("ar_owner", {30'b0, owner_a}, 32'h0);
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] after release gnt=%b owner=%0d", gnt_a, owner_a);
        chk("ar_first_gnt", {28'b0, gnt_a}, 32'h1);
        chk("ar_first_owner", {30'b0, owner_a}, 32'h0);

        // Long tenure from requester 1 with no last.
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            step(4'b0010, 4'b0000);
            $display("[TB] tenure cycle %0d gnt=%b timeout=%b", c, gnt_a, to_a);
            chk($sformatf("to_grant%0d", c), {28'b0, gnt_a}, 32'h2);
            chk($sformatf("to_pulse%0d", c), {31'b0, to_a}, 32'h0);
        end
        step(4'b0010, 4'b0000);
        $display("[TB] tenure cycle 5 gnt=%b busy=%b timeout=%b", gnt_a, busy_a, to_a);
`ifdef TRI_BUS_ARB_TIMEOUT_EN
        chk("to_release_gnt", {28'b0, gnt_a}, 32'h0);
        chk("to_release_busy", {31'b0, busy_a}, 32'h1);
        chk("to_release_pulse", {31'b0, to_a}, 32'h1);
`else
        chk("to_hold_gnt", {28'b0, gnt_a}, 32'h2);
        chk("to_hold_pulse", {31'b0, to_a}, 32'h0);
`endif
        step(4'b0010, 4'b0000);
        $display("[TB] tenure cycle 6 gnt=%b owner=%0d timeout=%b", gnt_a, owner_a, to_a);
        chk("to_regrant_gnt", {28'b0, gnt_a}, 32'h2);
        chk("to_regrant_owner", {30'b0, owner_a}, 32'h1);
        chk("to_regrant_pulse", {31'b0, to_a}, 32'h0);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        chk("to_idle_busy", {31'b0, busy_a}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
